xor_stream_engine: RTL and testbench
====================================

# xor_stream_engine

Byte-stream XOR cipher core and the read-side client of the key ROM. It accepts plaintext or ciphertext bytes over a valid/ready stream, drives the key ROM read address, and XORs each byte with the addressed key byte. It emits the result on an output stream with one register stage. Because XOR is symmetric, the same block performs both encryption and decryption between the input port logic and the output/display path.

## Interface
- B, 8, data and key byte width
- W, 4, key ROM address width
- KEY_LEN, 12, number of active key bytes; legal range 1..2**W
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- in_valid  input  1  input byte present
- in_ready  output  1  engine can accept a byte this cycle
- in_data  input  B  input byte
- in_last  input  1  byte is the final byte of a message
- restart  input  1  synchronous one-cycle pulse; realigns the key to index 0
- out_valid  output  1  output byte present
- out_ready  input  1  downstream accepts the output byte
- out_data  output  B  in_data XOR key byte
- out_last  output  1  in_last carried with the byte
- R_A  output  W  key ROM read address (equals the key index)
- R_D  input  B  key ROM read data, combinational from R_A
- msg_count  output  16  completed messages since reset; wraps at 0xFFFF -> 0

## Operation
- Key index register kidx (W bits) drives R_A directly. R_D is valid in the same cycle.
- Accept occurs when in_valid && in_ready. On accept:
  - out_data <= in_data ^ R_D
  - out_last <= in_last
  - out_valid <= 1
- kidx update on an accept, in priority order:
  - restart = 1 or in_last = 1: kidx <= 0.
  - kidx == KEY_LEN-1: kidx <= 0 (wrap).
  - Otherwise: kidx <= kidx+1.
- restart without an accept sets kidx <= 0. restart has no effect on a pending output byte.
- If restart coincides with an accept, the accepted byte uses the old kidx, then kidx becomes 0.
- Output register behaviour:
  - It holds out_data and out_last stable while out_valid && !out_ready.
  - out_valid clears on out_valid && out_ready when there is no new accept that cycle.
- msg_count increments when an output byte with out_last = 1 is consumed (out_valid && out_ready && out_last).
- The states are IDLE (out_valid = 0) and FULL (out_valid = 1):
  - IDLE -> FULL on accept.
  - FULL -> IDLE on consume without accept.
  - FULL -> FULL on consume with accept, or on a stall.
- Reset (asynchronous, reset = 0):
  - kidx = 0, R_A = 0, out_valid = 0, out_data = 0, out_last = 0, msg_count = 0.
  - in_ready is forced to 0 while reset is asserted.
  - An asserted reset mid-stream discards the pending byte with no partial output.

## Timing
- in_ready = reset && (!out_valid || out_ready), combinational. No combinational path exists from in_valid to out_valid.
- Latency is 1 cycle: a byte accepted at edge N appears on out_data after edge N, with out_valid = 1.
- Throughput is 1 byte/cycle while out_ready = 1.
- Back-pressure propagates combinationally: out_ready = 0 with out_valid = 1 forces in_ready = 0 in the same cycle.
- R_A changes only on clock edges (or on reset); R_D must settle within the cycle.
- msg_count updates on the edge at which the last byte is consumed.

## Test plan
- Key ROM loaded with 0x5A at even and 0x68 at odd addresses 0..11, and 0x00 at 12..15; KEY_LEN = 12; out_ready = 1; stream 13 bytes of 0x00 -> out_data is 5A,68,…,68 for the first 12 bytes, the 13th is 0x5A (wrap), and R_A sequence is 0..11,0.
- Input 0x41 at index 0 with out_ready = 0 for 3 cycles -> out_valid stays 1, out_data holds 0x1B, in_ready = 0. Release out_ready -> one transfer, no duplicate.
- 3-byte message with in_last on byte 3, then byte 0x00 -> out_last only on the third output; the next byte uses index 0 (0x5A); msg_count = 1 after consume.
- restart pulse coincident with accepting a byte at index 5 -> that byte is XORed with 0x68; the next byte uses index 0; the pending output is unaffected.
- Assert reset = 0 mid-stream with out_valid = 1 -> out_valid = 0, out_data = 0, R_A = 0, msg_count = 0 immediately (asynchronous), in_ready = 0. After release, the first byte uses index 0.
- Round trip: feed the output of one instance into a second instance with the same ROM, 24 random bytes -> the second output equals the original input.

Source files
------------

// File: rtl/xor_stream_engine.sv
// xor_stream_engine: byte-stream XOR cipher with key ROM read port and one output register stage
module xor_stream_engine #(
   parameter int B       = 8,
   parameter int W       = 4,
   parameter int KEY_LEN = 12
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [B-1:0] in_data,
   input  logic         in_last,
   input  logic         restart,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [B-1:0] out_data,
   output logic         out_last,
   output logic [W-1:0] R_A,
   input  logic [B-1:0] R_D,
   output logic [15:0]  msg_count
);
   typedef enum logic {IDLE, FULL} state_t;

   localparam logic [W-1:0] LAST_IDX = W'(KEY_LEN - 1);

   state_t       state, state_nxt;
   logic [W-1:0] kidx, kidx_nxt;
   logic         accept, consume;

   assign R_A       = kidx;
   assign out_valid = (state == FULL);
   assign in_ready  = reset && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign consume   = out_valid && out_ready;

   // next state and next key index; restart or end of message realign the key
   always_comb begin
      state_nxt = accept ? FULL : (consume ? IDLE : state);
      kidx_nxt  = kidx;
      if (restart || (accept && in_last))
         kidx_nxt = '0;
      else if (accept)
         kidx_nxt = (kidx == LAST_IDX) ? '0 : kidx + 1'b1;
   end

   // state, key index, output register and message counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         kidx      <= '0;
         out_data  <= '0;
         out_last  <= 1'b0;
         msg_count <= '0;
      end else begin
         state <= state_nxt;
         kidx  <= kidx_nxt;
         if (accept) begin
            out_data <= in_data ^ R_D;
            out_last <= in_last;
         end
         if (consume && out_last)
            msg_count <= msg_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_xor_stream_engine.sv
// tb_xor_stream_engine: directed checks of the XOR stream engine plus an encrypt/decrypt round trip
module tb_xor_stream_engine;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0, in_last = 1'b0, restart = 1'b0, out_ready = 1'b1;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready, out_valid, out_last;
   logic [7:0]  out_data, rd;
   logic [3:0]  ra;
   logic [15:0] msg_count;

   logic        a_valid = 1'b0, a_last = 1'b0, a_ready, b_valid, b_last, b_ready;
   logic [7:0]  a_data = 8'h00, b_data, c_data, rd1, rd2;
   logic        c_valid, c_last;
   logic [3:0]  ra1, ra2;
   logic [15:0] mc1, mc2;
   logic        rt_restart = 1'b0;

   logic [7:0]  rom [16];
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   assign rd  = rom[ra];
   assign rd1 = rom[ra1];
   assign rd2 = rom[ra2];

   xor_stream_engine dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .restart(restart), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .R_A(ra), .R_D(rd), .msg_count(msg_count));

   xor_stream_engine enc (
      .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
      .in_last(a_last), .restart(rt_restart), .out_valid(b_valid), .out_ready(b_ready),
      .out_data(b_data), .out_last(b_last), .R_A(ra1), .R_D(rd1), .msg_count(mc1));

   xor_stream_engine dec (
      .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
      .in_last(b_last), .restart(rt_restart), .out_valid(c_valid), .out_ready(1'b1),
      .out_data(c_data), .out_last(c_last), .R_A(ra2), .R_D(rd2), .msg_count(mc2));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] key_of(input int i);
      return (i < 12) ? ((i % 2) ? 8'h68 : 8'h5A) : 8'h00;
   endfunction

   initial begin
      logic [7:0] sent [24];
      logic       acc;
      int         tx, rx;
      logic [7:0] exp3 [3];
      for (int i = 0; i < 16; i++) rom[i] = key_of(i);
      exp3[0] = 8'h5A; exp3[1] = 8'h68; exp3[2] = 8'h5A;

      // reset state (asynchronous, before any clock edge)
      #1 reset = 1'b0;
      #2;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_last", out_last, 0);
      chk("rst_ra", ra, 0);
      chk("rst_msg", msg_count, 0);
      chk("rst_ready", in_ready, 0);
      step();
      step();
      reset = 1'b1;

      // 13 zero bytes: key sequence with wrap after index 11
      for (int i = 0; i < 13; i++) begin
         in_valid = 1'b1; in_data = 8'h00;
         chk("t1_ra", ra, i % 12);
         step();
         chk("t1_data", out_data, key_of(i % 12));
         chk("t1_valid", out_valid, 1);
      end
      in_valid = 1'b0; restart = 1'b1;
      step();
      restart = 1'b0;
      chk("t1_drain", out_valid, 0);
      chk("t1_restart_ra", ra, 0);

      // back-pressure: 0x41 at index 0 held for 3 stalled cycles
      in_valid = 1'b1; in_data = 8'h41; out_ready = 1'b0;
      step();
      in_data = 8'h55;
      chk("t2_ready", in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_valid", out_valid, 1);
         chk("t2_data", out_data, 8'h1B);
         chk("t2_ready", in_ready, 0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      chk("t2_release_ready", in_ready, 1);
      step();
      chk("t2_no_dup", out_valid, 0);
      chk("t2_ra", ra, 1);

      // message framing and msg_count
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("t3_ra0", ra, 0);
      for (int j = 0; j < 3; j++) begin
         in_valid = 1'b1; in_data = 8'h00; in_last = (j == 2);
         step();
         chk("t3_data", out_data, exp3[j]);
         chk("t3_last", out_last, (j == 2));
      end
      chk("t3_msg_pre", msg_count, 0);
      in_last = 1'b0; in_data = 8'h00;
      chk("t3_ra_after_last", ra, 0);
      step();
      chk("t3_msg", msg_count, 1);
      chk("t3_next_data", out_data, 8'h5A);
      chk("t3_next_last", out_last, 0);

      // restart coincident with an accept at index 5
      for (int j = 1; j < 5; j++) step();
      chk("t4_ra5", ra, 5);
      in_data = 8'hFF; restart = 1'b1;
      step();
      chk("t4_data", out_data, 8'h97);
      chk("t4_ra", ra, 0);
      in_valid = 1'b0; out_ready = 1'b0;
      step();
      restart = 1'b0;
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_data", out_data, 8'h97);
      chk("t4_hold_ra", ra, 0);
      out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h33;
      step();
      chk("t4_next", out_data, 8'h69);
      chk("t4_next_ra", ra, 1);

      // asynchronous reset mid-stream with a pending byte
      in_valid = 1'b0; out_ready = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("t5_valid", out_valid, 0);
      chk("t5_data", out_data, 0);
      chk("t5_ra", ra, 0);
      chk("t5_msg", msg_count, 0);
      chk("t5_ready", in_ready, 0);
      step();
      reset = 1'b1; out_ready = 1'b1;
      in_valid = 1'b1; in_data = 8'h41;
      chk("t5_post_ra", ra, 0);
      step();
      chk("t5_post_data", out_data, 8'h1B);
      in_valid = 1'b0;
      step();

      // round trip through encrypt and decrypt instances
      for (int i = 0; i < 24; i++) sent[i] = 8'($urandom_range(0, 255));
      tx = 0; rx = 0;
      for (int c = 0; c < 40; c++) begin
         a_valid = (tx < 24);
         a_data  = (tx < 24) ? sent[tx] : 8'h00;
         a_last  = (tx == 11);
         #1;
         acc = a_valid && a_ready;
         step();
         if (acc) tx++;
         if (c_valid) begin
            if (rx < 24) chk("rt_data", c_data, sent[rx]);
            rx++;
         end
      end
      chk("rt_count", rx, 24);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
